// File: rtl/topk_sort_chain_if.sv
// Valid/ready stream bundle for topk_sort_chain: candidate input stream and drained output stream.
// Records are packed {distance, pointa, pointb}, MSB first.
interface topk_sort_chain_if #(
  parameter int unsigned NUM_POINTS = 1000,
  parameter int unsigned DIM_W      = 17
);
  // Squared 3-D Euclidean distance of DIM_W-bit coordinates.
  localparam int unsigned DIST_W = 2 * DIM_W + 2;
  localparam int unsigned PT_W   = $clog2(NUM_POINTS);
  localparam int unsigned CONN_W = DIST_W + 2 * PT_W;

  logic [CONN_W-1:0] conn_in;
  logic              conn_in_vld;
  logic              conn_in_rdy;
  logic [CONN_W-1:0] conn_out;
  logic              conn_out_vld;
  logic              conn_out_rdy;
  logic              conn_out_last;

  modport master (
    output conn_in,
    output conn_in_vld,
    input  conn_in_rdy,
    input  conn_out,
    input  conn_out_vld,
    output conn_out_rdy,
    input  conn_out_last
  );

  modport slave (
    input  conn_in,
    input  conn_in_vld,
    output conn_in_rdy,
    output conn_out,
    output conn_out_vld,
    input  conn_out_rdy,
    output conn_out_last
  );
endinterface

// File: rtl/topk_sort_chain.sv
// Top-K selector: keeps the DEPTH best conn records sorted with single-cycle insertion, drains on request.
// Optional SORT_CHAIN_STATS_EN adds saturating accepted/dropped counters.
module topk_sort_chain #(
  parameter int unsigned NUM_POINTS = 1000,
  parameter int unsigned DIM_W      = 17,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SORT_OP    = 0,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    drain_start,
  topk_sort_chain_if.slave        bus,
  output logic                    drain_done,
  output logic [CNT_W-1:0]        count
`ifdef SORT_CHAIN_STATS_EN
  ,
  output logic [31:0]             stat_accepted,
  output logic [31:0]             stat_dropped
`endif
);

  localparam int unsigned DIST_W = 2 * DIM_W + 2;
  localparam int unsigned PT_W   = $clog2(NUM_POINTS);

  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [PT_W-1:0]   pointa;
    logic [PT_W-1:0]   pointb;
  } conn_t;

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  // Empty slots hold the worst possible distance so they never look better than real data.
  localparam logic [DIST_W-1:0] DistInit = (SORT_OP == 0) ? {DIST_W{1'b1}} : {DIST_W{1'b0}};
  localparam conn_t EntInit = '{distance: DistInit, pointa: '0, pointb: '0};

  if (SORT_OP > 1) begin : g_bad_sort_op
    $fatal(1, "topk_sort_chain: SORT_OP must be 0 or 1");
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $fatal(1, "topk_sort_chain: DEPTH must be in 2..256");
  end

  state_e           r_state, w_state_nxt;
  conn_t            r_ent     [DEPTH];
  conn_t            w_ent_nxt [DEPTH];
  conn_t            w_prev    [DEPTH];
  conn_t            w_next    [DEPTH];
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_done, w_done_nxt;
  conn_t            w_new;
  logic [DEPTH-1:0] w_keep;
  logic [DEPTH-1:0] w_ins;
  logic [DEPTH-1:0] w_shf;
  logic             w_accept;
  logic             w_full;
  logic             w_out_vld;
  logic             w_pop;

  assign w_new     = conn_t'(bus.conn_in);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_accept  = (r_state == StFill) && bus.conn_in_vld;
  assign w_out_vld = (r_state == StDrain) && (r_count != '0);
  assign w_pop     = w_out_vld && bus.conn_out_rdy;

  // Valid entries no worse than the candidate stay put; this is a prefix because the list is sorted.
  // Keeping equal entries ahead of the candidate makes insertion stable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic w_better;
    if (SORT_OP == 0) begin : g_min
      assign w_better = (w_new.distance < r_ent[gi].distance);
    end else begin : g_max
      assign w_better = (w_new.distance > r_ent[gi].distance);
    end
    assign w_keep[gi] = (CNT_W'(gi) < r_count) && !w_better;

    if (gi == 0) begin : g_head
      assign w_ins[gi]  = ~w_keep[gi];
      assign w_shf[gi]  = 1'b0;
      assign w_prev[gi] = EntInit;
    end else begin : g_body
      assign w_ins[gi]  = ~w_keep[gi] & w_keep[gi-1];
      assign w_shf[gi]  = ~w_keep[gi-1];
      assign w_prev[gi] = r_ent[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_tail
      assign w_next[gi] = EntInit;
    end else begin : g_mid
      assign w_next[gi] = r_ent[gi+1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_ent_nxt   = r_ent;
    unique case (r_state)
      StFill: begin
        // A full list whose entries are all kept discards the candidate: no slot selects it.
        if (w_accept) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_ins[i]) begin
              w_ent_nxt[i] = w_new;
            end else if (w_shf[i]) begin
              w_ent_nxt[i] = w_prev[i];
            end
          end
          if (!w_full) begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        if (drain_start) begin
          if ((r_count == '0) && !w_accept) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = StDrain;
          end
        end
      end
      StDrain: begin
        if (r_count == '0) begin
          w_state_nxt = StFill;
          w_done_nxt  = 1'b1;
        end else if (w_pop) begin
          for (int i = 0; i < DEPTH; i++) begin
            w_ent_nxt[i] = w_next[i];
          end
          w_count_nxt = r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            w_state_nxt = StFill;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = StFill;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_state <= StFill;
      r_count <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= EntInit;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_ent_nxt[i];
      end
    end
  end

  assign bus.conn_in_rdy   = (r_state == StFill);
  assign bus.conn_out      = w_out_vld ? r_ent[0] : '0;
  assign bus.conn_out_vld  = w_out_vld;
  assign bus.conn_out_last = (r_state == StDrain) && (r_count == CNT_W'(1));
  assign drain_done        = r_done;
  assign count             = r_count;

`ifdef SORT_CHAIN_STATS_EN
  logic [31:0] r_stat_acc;
  logic [31:0] r_stat_drop;

  // Accepting into a full list always loses one record: the old tail or the candidate itself.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_stat_acc  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_accept && (r_stat_acc != 32'hFFFF_FFFF)) begin
        r_stat_acc <= r_stat_acc + 32'd1;
      end
      if (w_accept && w_full && (r_stat_drop != 32'hFFFF_FFFF)) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign stat_accepted = r_stat_acc;
  assign stat_dropped  = r_stat_drop;
`endif

endmodule

// File: tb/tb_topk_sort_chain.sv
// Bench for topk_sort_chain: an ascending and a descending instance share one stimulus stream and are
// checked against a stable top-K selection over every record accepted since the list was last emptied.
module tb_topk_sort_chain;
  localparam int unsigned NP     = 1000;
  localparam int unsigned DW     = 17;
  localparam int unsigned K      = 4;
  localparam int unsigned DIST_W = 2 * DW + 2;
  localparam int unsigned PT_W   = $clog2(NP);
  localparam int unsigned CONN_W = DIST_W + 2 * PT_W;
  localparam int unsigned CNT_W  = $clog2(K + 1);

  typedef logic [CONN_W-1:0] rec_t;

  logic clk = 1'b0;
  logic rst_n, clear, drain_start, in_vld, out_rdy;
  rec_t in_rec;
  logic done_a, done_d;
  logic [CNT_W-1:0] cnt_a, cnt_d;
`ifdef SORT_CHAIN_STATS_EN
  logic [31:0] acc_a, drop_a, acc_d, drop_d;
`endif

  always #5 clk = ~clk;

  topk_sort_chain_if #(.NUM_POINTS(NP), .DIM_W(DW)) bus_a ();
  topk_sort_chain_if #(.NUM_POINTS(NP), .DIM_W(DW)) bus_d ();

  assign bus_a.conn_in      = in_rec;
  assign bus_a.conn_in_vld  = in_vld;
  assign bus_a.conn_out_rdy = out_rdy;
  assign bus_d.conn_in      = in_rec;
  assign bus_d.conn_in_vld  = in_vld;
  assign bus_d.conn_out_rdy = out_rdy;

  topk_sort_chain #(.NUM_POINTS(NP), .DIM_W(DW), .DEPTH(K), .SORT_OP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .drain_start(drain_start), .bus(bus_a),
    .drain_done(done_a), .count(cnt_a)
`ifdef SORT_CHAIN_STATS_EN
    , .stat_accepted(acc_a), .stat_dropped(drop_a)
`endif
  );

  topk_sort_chain #(.NUM_POINTS(NP), .DIM_W(DW), .DEPTH(K), .SORT_OP(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .clear(clear), .drain_start(drain_start), .bus(bus_d),
    .drain_done(done_d), .count(cnt_d)
`ifdef SORT_CHAIN_STATS_EN
    , .stat_accepted(acc_d), .stat_dropped(drop_d)
`endif
  );

  int checks = 0;
  int errors = 0;
  rec_t hist[$];
  rec_t exp_a[$], exp_d[$], obs_a[$], obs_d[$];
  bit   last_a[$], last_d[$];
  int   cnt_tr[$], hs_tr[$];
  int   stab_viol, vld_diff, cnt_diff, done_at, done_d_at, last_hs_at, done_after;
  bit   timed_out;

  function automatic logic [DIST_W-1:0] dist_of(rec_t r);
    return r[CONN_W-1 -: DIST_W];
  endfunction

  function automatic logic [PT_W-1:0] pa_of(rec_t r);
    return r[2*PT_W-1 -: PT_W];
  endfunction

  function automatic rec_t mk(logic [DIST_W-1:0] d, int unsigned pa, int unsigned pb);
    return {d, PT_W'(pa), PT_W'(pb)};
  endfunction

  function automatic rec_t rnd_rec();
    logic [DIST_W-1:0] d;
    d = ($urandom_range(0, 7) == 0) ? {DIST_W{1'b1}} : DIST_W'($urandom_range(0, 15));
    return mk(d, $urandom_range(0, NP - 1), $urandom_range(0, NP - 1));
  endfunction

  // Reference: stable selection of the K best records among everything accepted (earliest wins ties).
  task automatic model_expect();
    rec_t rem[$];
    int   bi;
    exp_a.delete();
    exp_d.delete();
    for (int op = 0; op < 2; op++) begin
      rem = hist;
      for (int k = 0; k < K && rem.size() > 0; k++) begin
        bi = 0;
        for (int j = 1; j < rem.size(); j++) begin
          if (op == 0 ? (dist_of(rem[j]) < dist_of(rem[bi])) : (dist_of(rem[j]) > dist_of(rem[bi])))
            bi = j;
        end
        if (op == 0) exp_a.push_back(rem[bi]);
        else exp_d.push_back(rem[bi]);
        rem.delete(bi);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(rec_t r);
    in_vld = 1'b1;
    in_rec = r;
    step();
    in_vld = 1'b0;
    hist.push_back(r);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    hist.delete();
  endtask

  // Pulses drain_start (optionally with a same-cycle candidate) and records the whole drain.
  task automatic collect(input int mode, input bit ins_vld, input rec_t ins_rec);
    bit   held;
    rec_t held_a, held_d;
    int   hs;
    held = 0; hs = 0;
    obs_a.delete(); obs_d.delete(); last_a.delete(); last_d.delete();
    cnt_tr.delete(); hs_tr.delete();
    stab_viol = 0; vld_diff = 0; cnt_diff = 0;
    done_at = -1; done_d_at = -1; last_hs_at = -1; timed_out = 1;
    drain_start = 1'b1;
    in_vld = ins_vld;
    in_rec = ins_rec;
    if (ins_vld) hist.push_back(ins_rec);
    model_expect();
    step();
    drain_start = 1'b0;
    in_vld = 1'b0;
    for (int it = 0; it < 64; it++) begin
      if (done_a || done_d) begin
        if (done_a) done_at = it;
        if (done_d) done_d_at = it;
        timed_out = 0;
        break;
      end
      case (mode)
        0: out_rdy = 1'b1;
        1: out_rdy = (it % 3 == 0);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      cnt_tr.push_back(int'(cnt_a));
      hs_tr.push_back(hs);
      if (cnt_a != cnt_d) cnt_diff++;
      if (bus_a.conn_out_vld != bus_d.conn_out_vld) vld_diff++;
      if (held && (bus_a.conn_out != held_a || bus_d.conn_out != held_d)) stab_viol++;
      held = 0;
      if (bus_a.conn_out_vld) begin
        if (out_rdy) begin
          obs_a.push_back(bus_a.conn_out);
          obs_d.push_back(bus_d.conn_out);
          last_a.push_back(bus_a.conn_out_last);
          last_d.push_back(bus_d.conn_out_last);
          hs++;
          last_hs_at = it;
        end else begin
          held = 1; held_a = bus_a.conn_out; held_d = bus_d.conn_out;
        end
      end
      step();
    end
    out_rdy = 1'b0;
    step();
    done_after = int'(done_a | done_d);
    hist.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; drain_start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_rec = '0;
    repeat (3) step();
    checks++; if (cnt_a !== 0 || cnt_d !== 0) begin errors++;
      $display("FAIL reset_count: got %0d/%0d expected 0", cnt_a, cnt_d); end
    checks++; if (bus_a.conn_out_vld !== 1'b0 || bus_d.conn_out_vld !== 1'b0) begin errors++;
      $display("FAIL reset_vld: got %b/%b expected 0", bus_a.conn_out_vld, bus_d.conn_out_vld); end
    checks++; if (bus_a.conn_out !== '0 || bus_d.conn_out !== '0 || bus_a.conn_out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out: got %0h/%0h expected 0", bus_a.conn_out, bus_d.conn_out); end
    checks++; if (bus_a.conn_in_rdy !== 1'b1 || done_a !== 1'b0) begin errors++;
      $display("FAIL reset_rdy_done: got rdy=%b done=%b expected 1/0", bus_a.conn_in_rdy, done_a); end
`ifdef SORT_CHAIN_STATS_EN
    checks++; if (acc_a !== 0 || drop_a !== 0) begin errors++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", acc_a, drop_a); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d[5] = '{50, 10, 30, 20, 40};
    int la[4] = '{10, 20, 30, 40};
    int ld[4] = '{50, 40, 30, 20};
    do_clear();
    for (int i = 0; i < 5; i++) push(mk(DIST_W'(d[i]), i, i + 1));
    checks++; if (cnt_a !== 4 || cnt_d !== 4) begin errors++;
      $display("FAIL basic_count_full: got %0d/%0d expected 4", cnt_a, cnt_d); end
`ifdef SORT_CHAIN_STATS_EN
    checks++; if (acc_a !== 5 || drop_a !== 1 || acc_d !== 5 || drop_d !== 1) begin errors++;
      $display("FAIL basic_stats: got %0d/%0d expected 5/1", acc_a, drop_a); end
`endif
    collect(0, 0, '0);
    checks++; if (timed_out || obs_a.size() != 4) begin errors++;
      $display("FAIL basic_beats: got %0d expected 4", obs_a.size()); end
    for (int i = 0; i < obs_a.size() && i < 4; i++) begin
      checks++; if (dist_of(obs_a[i]) !== DIST_W'(la[i]) || dist_of(obs_d[i]) !== DIST_W'(ld[i])) begin
        errors++; $display("FAIL basic_order[%0d]: got %0d/%0d expected %0d/%0d", i,
                           dist_of(obs_a[i]), dist_of(obs_d[i]), la[i], ld[i]); end
      checks++; if (last_a[i] !== (i == 3) || last_d[i] !== (i == 3)) begin errors++;
        $display("FAIL basic_last[%0d]: got %b expected %b", i, last_a[i], i == 3); end
    end
    checks++; if (last_hs_at !== 3 || done_at !== 4 || done_d_at !== 4 || done_after !== 0) begin
      errors++; $display("FAIL basic_done: got hs=%0d done=%0d after=%0d expected 3/4/0",
                         last_hs_at, done_at, done_after); end
    for (int i = 0; i < cnt_tr.size(); i++) begin
      checks++; if (cnt_tr[i] !== 4 - hs_tr[i]) begin errors++;
        $display("FAIL basic_count_trace[%0d]: got %0d expected %0d", i, cnt_tr[i], 4 - hs_tr[i]); end
    end
    checks++; if (cnt_a !== 0 || bus_a.conn_in_rdy !== 1'b1 || bus_d.conn_in_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_post: got cnt=%0d rdy=%b expected 0/1", cnt_a, bus_a.conn_in_rdy); end
`ifdef SORT_CHAIN_STATS_EN
    checks++; if (acc_a !== 5 || drop_a !== 1) begin errors++;
      $display("FAIL basic_stats_held: got %0d/%0d expected 5/1", acc_a, drop_a); end
`endif
  endtask

  task automatic test_ties();
    do_clear();
    push(mk(5, 1, 0)); push(mk(9, 2, 0)); push(mk(1, 3, 0)); push(mk(9, 7, 0)); push(mk(7, 5, 0));
    collect(0, 0, '0);
    checks++; if (obs_d.size() != 4) begin errors++;
      $display("FAIL ties_beats: got %0d expected 4", obs_d.size()); end
    if (obs_d.size() >= 2) begin
      checks++; if (pa_of(obs_d[0]) !== 2 || pa_of(obs_d[1]) !== 7 || dist_of(obs_d[1]) !== 9) begin
        errors++; $display("FAIL ties_stable: got pointa %0d,%0d expected 2,7",
                           pa_of(obs_d[0]), pa_of(obs_d[1])); end
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin errors++;
        $display("FAIL ties_model[%0d]: got %0h/%0h expected %0h/%0h", i, obs_a[i], obs_d[i],
                 exp_a[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    for (int i = 0; i < 6; i++) push(rnd_rec());
    collect(1, 0, '0);
    checks++; if (timed_out || stab_viol != 0 || vld_diff != 0 || cnt_diff != 0) begin errors++;
      $display("FAIL bp_stability: got to=%b stab=%0d vld=%0d cnt=%0d expected all 0", timed_out,
               stab_viol, vld_diff, cnt_diff); end
    checks++; if (obs_a.size() != exp_a.size() || obs_d.size() != exp_d.size()) begin errors++;
      $display("FAIL bp_beats: got %0d expected %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin errors++;
        $display("FAIL bp_data[%0d]: got %0h/%0h expected %0h/%0h", i, obs_a[i], obs_d[i],
                 exp_a[i], exp_d[i]); end
    end
    for (int i = 0; i < cnt_tr.size(); i++) begin
      checks++; if (cnt_tr[i] !== int'(K) - hs_tr[i]) begin errors++;
        $display("FAIL bp_count[%0d]: got %0d expected %0d", i, cnt_tr[i], int'(K) - hs_tr[i]); end
    end
  endtask

  task automatic test_empty_drain();
    do_clear();
    collect(0, 0, '0);
    checks++; if (obs_a.size() != 0 || vld_diff != 0) begin errors++;
      $display("FAIL empty_beats: got %0d expected 0", obs_a.size()); end
    checks++; if (done_at !== 0 || done_d_at !== 0 || done_after !== 0) begin errors++;
      $display("FAIL empty_done: got at=%0d after=%0d expected 0/0", done_at, done_after); end
    checks++; if (bus_a.conn_in_rdy !== 1'b1 || bus_a.conn_out_vld !== 1'b0) begin errors++;
      $display("FAIL empty_rdy: got %b expected 1", bus_a.conn_in_rdy); end
  endtask

  task automatic test_insert_with_drain();
    do_clear();
    push(mk(10, 1, 1)); push(mk(20, 2, 2));
    collect(0, 1, mk(3, 3, 3));
    checks++; if (obs_a.size() != 3) begin errors++;
      $display("FAIL insdrain_beats: got %0d expected 3", obs_a.size()); end
    if (obs_a.size() == 3) begin
      checks++; if (dist_of(obs_a[0]) !== 3 || dist_of(obs_a[1]) !== 10 || dist_of(obs_a[2]) !== 20)
      begin errors++; $display("FAIL insdrain_order: got %0d,%0d,%0d expected 3,10,20",
                               dist_of(obs_a[0]), dist_of(obs_a[1]), dist_of(obs_a[2])); end
      checks++; if (dist_of(obs_d[0]) !== 20 || dist_of(obs_d[2]) !== 3 || last_a[2] !== 1'b1) begin
        errors++; $display("FAIL insdrain_desc: got %0d..%0d expected 20..3",
                           dist_of(obs_d[0]), dist_of(obs_d[2])); end
    end
  endtask

  task automatic test_abort(input bit use_rst);
    do_clear();
    for (int i = 0; i < 4; i++) push(rnd_rec());
    drain_start = 1'b1; step(); drain_start = 1'b0;
    out_rdy = 1'b1; step(); step();
    checks++; if (cnt_a !== 2) begin errors++;
      $display("FAIL abort_pre_count: got %0d expected 2", cnt_a); end
    if (use_rst) rst_n = 1'b0; else clear = 1'b1;
    step();
    rst_n = 1'b1; clear = 1'b0; out_rdy = 1'b0; hist.delete();
    checks++; if (cnt_a !== 0 || cnt_d !== 0 || bus_a.conn_out_vld !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL abort_state: got cnt=%0d vld=%b done=%b expected 0/0/0", cnt_a,
                         bus_a.conn_out_vld, done_a); end
    checks++; if (bus_a.conn_in_rdy !== 1'b1 || bus_d.conn_in_rdy !== 1'b1) begin errors++;
      $display("FAIL abort_fill: got rdy=%b expected 1", bus_a.conn_in_rdy); end
`ifdef SORT_CHAIN_STATS_EN
    checks++; if (acc_a !== 0 || drop_a !== 0) begin errors++;
      $display("FAIL abort_stats: got %0d/%0d expected 0/0", acc_a, drop_a); end
`endif
    step();
    checks++; if (done_a !== 1'b0 || done_d !== 1'b0) begin errors++;
      $display("FAIL abort_no_done: got %b expected 0", done_a); end
    for (int i = 0; i < 3; i++) push(rnd_rec());
    collect(0, 0, '0);
    checks++; if (obs_a.size() != 3) begin errors++;
      $display("FAIL abort_refill_beats: got %0d expected 3", obs_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin errors++;
        $display("FAIL abort_refill[%0d]: got %0h expected %0h", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) push(rnd_rec());
      checks++; if (int'(cnt_a) !== ((n < int'(K)) ? n : int'(K))) begin errors++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", r, cnt_a, (n < int'(K)) ? n : K); end
      collect($urandom_range(0, 2), 0, '0);
      checks++; if (timed_out || obs_a.size() != exp_a.size() || stab_viol != 0 || vld_diff != 0) begin
        errors++; $display("FAIL rand_beats[%0d]: got %0d stab=%0d expected %0d", r, obs_a.size(),
                           stab_viol, exp_a.size()); end
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
        checks++; if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin errors++;
          $display("FAIL rand_data[%0d.%0d]: got %0h/%0h expected %0h/%0h", r, i, obs_a[i], obs_d[i],
                   exp_a[i], exp_d[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_empty_drain();
    test_insert_with_drain();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
